// File: rtl/dmem_responder_if.sv
// Request/response bundle between an initiator and dmem_responder.
// The initiator drives req_* and the responder drives r_data, r_data_status and err.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic [31:0] r_data;
    logic [1:0]  r_data_status;
    logic        err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  r_data, r_data_status, err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output r_data, r_data_status, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder with a 4-phase valid/status handshake.
// Define DMEM_RESPONDER_ERR_CHECK_EN to fault misaligned or out-of-range addresses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 3,
    parameter logic [31:0] DATA_BASE   = 32'h1000_0000
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    // Encodings double as the r_data_status value.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StBusy  = 2'b01,
        StDone  = 2'b10,
        StFault = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] r_data_q;
    logic        accept;
    logic        access;
    logic        fault;
    logic [31:0] offset;
    logic [AW-1:0] idx;
    logic        unused_bits;

    logic [31:0] mem [DEPTH_WORDS];

    assign offset = addr_q - DATA_BASE;
    assign idx    = offset[AW+1:2];

`ifdef DMEM_RESPONDER_ERR_CHECK_EN
    logic err_q;

    assign fault       = (addr_q[1:0] != 2'b00) || ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));
    assign unused_bits = ^offset[1:0];
    assign bus.err     = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (access && fault) begin
            err_q <= 1'b1;
        end
    end
`else
    assign fault       = 1'b0;
    assign unused_bits = ^{offset[31:AW+2], offset[1:0]};
    assign bus.err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = fault ? StFault : StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone, StFault: begin
                if (!bus.req_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
            r_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
            end
            if (access && !write_q && !fault) begin
                r_data_q <= mem[idx];
            end
        end
    end

    // Storage is deliberately not reset; reset only blocks the write via state.
    always_ff @(posedge clk) begin
        if (access && write_q && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.r_data        = r_data_q;
    assign bus.r_data_status = state_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected completions,
// a negedge monitor checks each completion; a LATENCY=1 instance checks throughput.
module tb_dmem_responder;
    localparam int LAT = 3;
`ifdef DMEM_RESPONDER_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  st;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    dmem_responder_if bus ();
    dmem_responder_if bus1 ();

    dmem_responder #(.LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
    dmem_responder #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Completion monitor: fires on entry into DONE/FAULT.
    logic [1:0] prev_st = 2'b00;
    always @(negedge clk) begin
        if (bus.r_data_status[1] && !prev_st[1]) begin
            if (sb.size() == 0) begin
                check("unexpected_completion", {30'd0, bus.r_data_status}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("status", {30'd0, bus.r_data_status}, {30'd0, e.st});
                check("r_data", bus.r_data, e.data);
                check("err", {31'd0, bus.err}, {31'd0, e.err});
            end
        end
        prev_st = bus.r_data_status;
    end

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [1:0] est, input logic [31:0] edata,
                          input logic eerr, input int hold, input bit drop_early);
        int busy;
        bit got;
        exp_t e;
        e.st = est;
        e.data = edata;
        e.err = eerr;
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_be    = be;
        busy = 0;
        got  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.r_data_status == 2'b01) begin
                busy++;
                // Scramble request fields; the latched copy must be used.
                bus.req_write = ~wr;
                bus.req_addr  = addr ^ 32'h0000_0FF0;
                bus.req_wdata = ~wd;
                bus.req_be    = ~be;
                if (drop_early) bus.req_valid = 1'b0;
            end else begin
                got = 1'b1;
                break;
            end
        end
        check("completed", {31'd0, got}, 32'd1);
        check("busy_cycles", busy, LAT);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_status", {30'd0, bus.r_data_status}, {30'd0, est});
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("back_to_idle", {30'd0, bus.r_data_status}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cycles;
        int busy1;
        bit got1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus1.req_valid = 1'b0;
        bus1.req_write = 1'b0;
        bus1.req_addr  = 32'h1000_0000;
        bus1.req_wdata = '0;
        bus1.req_be    = '0;
        #1;
        check("rst_status", {30'd0, bus.r_data_status}, 32'd0);
        check("rst_r_data", bus.r_data, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_req(1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0000_0000, 0, 0, 0);
        do_req(0, 32'h1000_0010, 32'h0,         4'h0, 2'b10, 32'hDEAD_BEEF, 0, 0, 0);
        do_req(1, 32'h1000_0010, 32'h0000_00AA, 4'h1, 2'b10, 32'hDEAD_BEEF, 0, 0, 0);
        do_req(0, 32'h1000_0010, 32'h0,         4'h0, 2'b10, 32'hDEAD_BEAA, 0, 0, 0);
        do_req(1, 32'h1000_0010, 32'h5555_5555, 4'h0, 2'b10, 32'hDEAD_BEAA, 0, 0, 0);
        do_req(0, 32'h1000_0010, 32'h0,         4'h0, 2'b10, 32'hDEAD_BEAA, 0, 0, 0);
        do_req(1, 32'h1000_0010, 32'h0BAD_0000, 4'hC, 2'b10, 32'hDEAD_BEAA, 0, 0, 1);
        do_req(0, 32'h1000_0010, 32'h0,         4'h0, 2'b10, 32'h0BAD_BEAA, 0, 0, 0);
        do_req(1, 32'h1000_0020, 32'h1111_1111, 4'hF, 2'b10, 32'h0BAD_BEAA, 0, 0, 0);
        do_req(0, 32'h1000_0020, 32'h0,         4'h0, 2'b10, 32'h1111_1111, 0, 5, 0);

        // Reset during a store: access discarded, outputs clear at once.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h1000_0020;
        bus.req_wdata = 32'h1234_5678;
        bus.req_be    = 4'hF;
        @(negedge clk);
        check("pre_rst_busy", {30'd0, bus.r_data_status}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_status", {30'd0, bus.r_data_status}, 32'd0);
        check("mid_rst_r_data", bus.r_data, 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        do_req(0, 32'h1000_0020, 32'h0,         4'h0, 2'b10, 32'h1111_1111, 0, 0, 0);
        do_req(1, 32'h1000_0000, 32'hCAFE_F00D, 4'hF, 2'b10, 32'h1111_1111, 0, 0, 0);
        if (ERR_EN) begin
            do_req(0, 32'h1000_0002, 32'h0, 4'h0, 2'b11, 32'h1111_1111, 1, 0, 0);
            do_req(0, 32'h1000_1000, 32'h0, 4'h0, 2'b11, 32'h1111_1111, 1, 0, 0);
            do_req(0, 32'h1000_0000, 32'h0, 4'h0, 2'b10, 32'hCAFE_F00D, 1, 0, 0);
        end else begin
            do_req(0, 32'h1000_0002, 32'h0, 4'h0, 2'b10, 32'hCAFE_F00D, 0, 0, 0);
            do_req(0, 32'h1000_1000, 32'h0, 4'h0, 2'b10, 32'hCAFE_F00D, 0, 0, 0);
            do_req(0, 32'h1000_0000, 32'h0, 4'h0, 2'b10, 32'hCAFE_F00D, 0, 0, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("err_cleared", {31'd0, bus.err}, 32'd0);

        // LATENCY=1 throughput: 10 back-to-back loads.
        cycles = 0;
        for (int k = 0; k < 10; k++) begin
            bus1.req_valid = 1'b1;
            busy1 = 0;
            got1  = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                cycles++;
                if (bus1.r_data_status == 2'b01) begin
                    busy1++;
                end else if (bus1.r_data_status == 2'b10) begin
                    got1 = 1'b1;
                    break;
                end
            end
            check("lat1_done", {31'd0, got1}, 32'd1);
            check("lat1_busy", busy1, 1);
            bus1.req_valid = 1'b0;
            @(negedge clk);
            cycles++;
            check("lat1_idle", {30'd0, bus1.r_data_status}, 32'd0);
        end
        check("lat1_total_cycles", cycles, 30);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
